ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
- Input-side counterpart of the memory-mapped display. Receives PS/2 device-to-host frames and decodes set-2 scan codes into Hack keyboard codes.
- Presents the result as the 16-bit read-only keyboard register that the CPU reads at address 24576.
- Holds the code of the key currently pressed, or 0 when no mapped key is pressed.

Parameters:
- TIMEOUT_CYCLES, 10000, clk cycles allowed between consecutive ps2_clk falling edges inside a frame before the frame is aborted.

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  PS/2 clock line, asynchronous to clk.
- ps2_data  input  1  PS/2 data line, asynchronous to clk.
- out  output  16  keyboard register: Hack key code, or 0.
- key_event  output  1  one-cycle pulse whenever out changes value.
- frame_err  output  1  one-cycle pulse on a parity error, bad start/stop bit, or timeout.

Behaviour:
- Reset: out=0, key_event=0, frame_err=0. Receiver goes to IDLE and decoder goes to NORMAL. Reset asserted mid-frame discards the partial frame.
- Sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is detected from the registered previous value of synced ps2_clk. Data is sampled on the detected edge.
- Receiver FSM:
  - IDLE: on a falling edge, if data=0 go to DATA with bit count 0. Otherwise stay in IDLE and pulse frame_err.
  - DATA: shift in 8 bits, LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: the frame is good if data=1 and the 9 bits (8 data + parity) have odd parity. A good frame emits the byte to the decoder with a one-cycle internal strobe. A bad frame pulses frame_err and emits nothing. Return to IDLE.
- Timeout: in any state other than IDLE, a counter resets on each falling edge. If it reaches TIMEOUT_CYCLES, go to IDLE and pulse frame_err.
- Latency: out and key_event update on the 3rd rising clk edge after the 11th ps2_clk falling edge at the pin, with data stable.
- Decoder FSM (states NORMAL, BREAK, EXT, EXT_BREAK):
  - 0xE0: NORMAL->EXT.
  - 0xF0: NORMAL->BREAK, EXT->EXT_BREAK.
  - Any other byte is a code and the FSM returns to NORMAL.
  - A make code is a code received in NORMAL or EXT. If mapped, it sets out to the mapped value.
  - A break code is a code received in BREAK or EXT_BREAK. It clears out to 0 only if its mapped value equals the current out. Otherwise out is unchanged.
  - Unmapped codes leave out unchanged but still return the FSM to NORMAL.
- Map, non-extended:
  - Letters to uppercase ASCII 65-90: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F, 34=G, 33=H, 43=I, 3B=J, 42=K, 4B=L, 3A=M, 31=N, 44=O, 4D=P, 15=Q, 2D=R, 1B=S, 2C=T, 3C=U, 2A=V, 1D=W, 22=X, 35=Y, 1A=Z.
  - Digits to 48-57: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - 29 space=32, 5A enter=128, 66 backspace=129, 76 esc=140.
- Map, extended (after E0): 6B left=130, 75 up=131, 74 right=132, 72 down=133, 6C home=134, 69 end=135, 7D pgup=136, 7A pgdn=137, 70 ins=138, 71 del=139.
- The same byte has a different meaning with and without E0. For example, 6B without E0 is unmapped.
- key_event pulses only when out actually changes. Typematic repeats of the held make code produce no pulse.
- out bits 15:8 are always 0.

Test Plan:
- Frame 0x1C with parity 0 and stop 1 -> out=65 three clks after the 11th falling edge, key_event pulses once. Then frames F0,1C -> out=0, key_event pulses.
- Frames E0,6B -> out=130. Then E0,F0,6B -> out=0. A bare 6B make -> out unchanged.
- Frame 0x1C with the parity bit flipped -> frame_err pulses once, out stays 0, the next good 0x1C frame gives out=65.
- Make 1C, make 32, break 1C -> out=66, unchanged by the break. Then break 32 -> out=0. Repeated 32 makes -> no extra key_event.
- Stop after 5 data bits for TIMEOUT_CYCLES+2 clks -> frame_err pulses, receiver in IDLE, the next full 0x29 frame gives out=32.
- Assert reset mid-frame after 3 bits with out=65 -> out=0 immediately (asynchronous). After release, a clean 0x45 frame gives out=48.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver: decodes scan codes into the Hack
// keyboard register (0 when no mapped key is held).
module ps2_keyboard #(
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] out,
   output logic        key_event,
   output logic        frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_t;
   typedef enum logic [1:0] {NORMAL, BREAK, EXT, EXT_BREAK} dec_t;

   rx_t           rx;
   dec_t          dec;
   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_prev;
   logic [7:0]    shreg;
   logic [2:0]    cnt;
   logic          par;
   logic [TW-1:0] tcnt;
   logic [7:0]    key;
   logic          fall;
   logic          din;
   logic          strobe;
   logic          ext;
   logic          brk;
   logic [7:0]    code;

   function automatic logic [7:0] map_key(input logic e, input logic [7:0] b);
      logic [7:0] m;
      m = 8'd0;
      if (e) begin
         case (b)
            8'h6B: m = 8'd130;
            8'h75: m = 8'd131;
            8'h74: m = 8'd132;
            8'h72: m = 8'd133;
            8'h6C: m = 8'd134;
            8'h69: m = 8'd135;
            8'h7D: m = 8'd136;
            8'h7A: m = 8'd137;
            8'h70: m = 8'd138;
            8'h71: m = 8'd139;
            default: m = 8'd0;
         endcase
      end else begin
         case (b)
            8'h1C: m = 8'd65;  8'h32: m = 8'd66;  8'h21: m = 8'd67;
            8'h23: m = 8'd68;  8'h24: m = 8'd69;  8'h2B: m = 8'd70;
            8'h34: m = 8'd71;  8'h33: m = 8'd72;  8'h43: m = 8'd73;
            8'h3B: m = 8'd74;  8'h42: m = 8'd75;  8'h4B: m = 8'd76;
            8'h3A: m = 8'd77;  8'h31: m = 8'd78;  8'h44: m = 8'd79;
            8'h4D: m = 8'd80;  8'h15: m = 8'd81;  8'h2D: m = 8'd82;
            8'h1B: m = 8'd83;  8'h2C: m = 8'd84;  8'h3C: m = 8'd85;
            8'h2A: m = 8'd86;  8'h1D: m = 8'd87;  8'h22: m = 8'd88;
            8'h35: m = 8'd89;  8'h1A: m = 8'd90;
            8'h45: m = 8'd48;  8'h16: m = 8'd49;  8'h1E: m = 8'd50;
            8'h26: m = 8'd51;  8'h25: m = 8'd52;  8'h2E: m = 8'd53;
            8'h36: m = 8'd54;  8'h3D: m = 8'd55;  8'h3E: m = 8'd56;
            8'h46: m = 8'd57;
            8'h29: m = 8'd32;  8'h5A: m = 8'd128;
            8'h66: m = 8'd129; 8'h76: m = 8'd140;
            default: m = 8'd0;
         endcase
      end
      return m;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
      end
   end

   assign fall = clk_prev & ~clk_sync[1];
   assign din  = data_sync[1];
   // The stop-bit edge feeds the decoder directly to keep the 3-clk latency
   assign strobe = fall & (rx == STOP) & din & (^{shreg, par});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx        <= IDLE;
         shreg     <= 8'd0;
         cnt       <= 3'd0;
         par       <= 1'b0;
         tcnt      <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (rx != IDLE && !fall && tcnt == TMAX) begin
            rx        <= IDLE;
            tcnt      <= '0;
            frame_err <= 1'b1;
         end else if (fall) begin
            tcnt <= '0;
            unique case (rx)
               IDLE: begin
                  if (!din) begin
                     rx  <= DATA;
                     cnt <= 3'd0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               DATA: begin
                  shreg <= {din, shreg[7:1]};
                  cnt   <= cnt + 3'd1;
                  if (cnt == 3'd7) rx <= PARITY;
               end
               PARITY: begin
                  par <= din;
                  rx  <= STOP;
               end
               STOP: begin
                  if (!strobe) frame_err <= 1'b1;
                  rx <= IDLE;
               end
            endcase
         end else if (rx != IDLE) begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

   assign ext  = (dec == EXT) || (dec == EXT_BREAK);
   assign brk  = (dec == BREAK) || (dec == EXT_BREAK);
   assign code = map_key(ext, shreg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec       <= NORMAL;
         key       <= 8'd0;
         key_event <= 1'b0;
      end else begin
         key_event <= 1'b0;
         if (strobe) begin
            if (dec == NORMAL && shreg == 8'hE0) begin
               dec <= EXT;
            end else if (dec == NORMAL && shreg == 8'hF0) begin
               dec <= BREAK;
            end else if (dec == EXT && shreg == 8'hF0) begin
               dec <= EXT_BREAK;
            end else begin
               dec <= NORMAL;
               if (code != 8'd0) begin
                  if (!brk && key != code) begin
                     key       <= code;
                     key_event <= 1'b1;
                  end else if (brk && key == code) begin
                     key       <= 8'd0;
                     key_event <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign out = {8'h00, key};

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: table of PS/2 frames with a scoreboard queue,
// plus timeout and mid-frame reset sequences.
module tb_ps2_keyboard;

   localparam int TO = 200;

   logic        clk;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] out;
   logic        key_event;
   logic        frame_err;

   ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .out       (out),
      .key_event (key_event),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  code;
      logic        flip;
      logic [15:0] exp_out;
      int          exp_ev;
      int          exp_err;
   } vec_t;

   vec_t        vecs[21];
   vec_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          ev_cnt = 0;
   int          err_cnt = 0;
   logic [15:0] prev_out = 16'd0;

   always @(negedge clk) begin
      if (key_event === 1'b1) ev_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic clk_bit(input logic v);
      @(negedge clk);
      ps2_data = v;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (6) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic flip);
      return {1'b1, (~^b) ^ flip, b, 1'b0};
   endfunction

   task automatic run_frame(input vec_t v);
      logic [10:0] bits;
      vec_t        e;
      int          ev0;
      int          er0;
      exp_q.push_back(v);
      ev0  = ev_cnt;
      er0  = err_cnt;
      bits = frame_bits(v.code, v.flip);
      for (int i = 0; i < 10; i++) clk_bit(bits[i]);
      @(negedge clk);
      ps2_data = bits[10];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("out_before_latency", int'(out), int'(prev_out));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("out_%02h", e.code), int'(out), int'(e.exp_out));
      check($sformatf("err_%02h", e.code), int'(frame_err), e.exp_err);
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
      check($sformatf("ev_count_%02h", e.code), ev_cnt - ev0, e.exp_ev);
      check($sformatf("err_count_%02h", e.code), err_cnt - er0, e.exp_err);
      prev_out = e.exp_out;
   endtask

   initial begin
      vec_t        v;
      logic [10:0] bits;
      int          er0;

      vecs[0]  = '{8'h1C, 1'b0, 16'd65,  1, 0};
      vecs[1]  = '{8'hF0, 1'b0, 16'd65,  0, 0};
      vecs[2]  = '{8'h1C, 1'b0, 16'd0,   1, 0};
      vecs[3]  = '{8'hE0, 1'b0, 16'd0,   0, 0};
      vecs[4]  = '{8'h6B, 1'b0, 16'd130, 1, 0};
      vecs[5]  = '{8'hE0, 1'b0, 16'd130, 0, 0};
      vecs[6]  = '{8'hF0, 1'b0, 16'd130, 0, 0};
      vecs[7]  = '{8'h6B, 1'b0, 16'd0,   1, 0};
      vecs[8]  = '{8'h6B, 1'b0, 16'd0,   0, 0};
      vecs[9]  = '{8'h1C, 1'b1, 16'd0,   0, 1};
      vecs[10] = '{8'h1C, 1'b0, 16'd65,  1, 0};
      vecs[11] = '{8'h32, 1'b0, 16'd66,  1, 0};
      vecs[12] = '{8'hF0, 1'b0, 16'd66,  0, 0};
      vecs[13] = '{8'h1C, 1'b0, 16'd66,  0, 0};
      vecs[14] = '{8'hF0, 1'b0, 16'd66,  0, 0};
      vecs[15] = '{8'h32, 1'b0, 16'd0,   1, 0};
      vecs[16] = '{8'h32, 1'b0, 16'd66,  1, 0};
      vecs[17] = '{8'h32, 1'b0, 16'd66,  0, 0};
      vecs[18] = '{8'h32, 1'b0, 16'd66,  0, 0};
      vecs[19] = '{8'hF0, 1'b0, 16'd66,  0, 0};
      vecs[20] = '{8'h32, 1'b0, 16'd0,   1, 0};

      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_out", int'(out), 0);
      check("reset_key_event", int'(key_event), 0);
      check("reset_frame_err", int'(frame_err), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 21; i++) run_frame(vecs[i]);

      // Abandon a frame after 5 data bits and let the receiver time out
      er0  = err_cnt;
      bits = frame_bits(8'h29, 1'b0);
      for (int i = 0; i < 6; i++) clk_bit(bits[i]);
      repeat (TO + 2) @(negedge clk);
      check("timeout_err_count", err_cnt - er0, 1);
      check("timeout_out", int'(out), 0);
      v = '{8'h29, 1'b0, 16'd32, 1, 0};
      run_frame(v);

      v = '{8'h1C, 1'b0, 16'd65, 1, 0};
      run_frame(v);
      bits = frame_bits(8'h33, 1'b0);
      for (int i = 0; i < 3; i++) clk_bit(bits[i]);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_reset_out", int'(out), 0);
      ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      prev_out = 16'd0;
      repeat (5) @(negedge clk);
      v = '{8'h45, 1'b0, 16'd48, 1, 0};
      run_frame(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
